// File: rtl/vga_clock_pkg.sv
// Shared digit widths, field limits and hour-format helper for the clock display path.
package vga_clock_pkg;

  localparam int unsigned DEFAULT_TICKS_PER_SEC = 31_500_000;

  localparam int unsigned SEC_U_W = 4;
  localparam int unsigned SEC_D_W = 3;
  localparam int unsigned MIN_U_W = 4;
  localparam int unsigned MIN_D_W = 3;
  localparam int unsigned HRS_U_W = 4;
  localparam int unsigned HRS_D_W = 2;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HRS_MAX = 23;

  // 0..23 -> 1..12 clock-face hour
  function automatic logic [4:0] hrs_to_12h(input logic [4:0] h);
    if (h == 5'd0)
      return 5'd12;
    else if (h > 5'd12)
      return h - 5'd12;
    else
      return h;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single modulo-MOD digit register with combinational carry-out on wrap.
module bcd_digit_counter #(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry_out
);

  assign carry_out = inc && (value == W'(MOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= '0;
    else if (clr)
      value <= '0;
    else if (inc)
      value <= carry_out ? '0 : value + W'(1);
  end

endmodule

// File: rtl/time_counter_bcd.sv
// 1 s prescaler and HH:MM:SS BCD time registers with single-cycle full carry.
// Optional TIME_12H_EN: registered 12-hour output mapping with pm flag (one extra cycle).
module time_counter_bcd
  import vga_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               adj_sec,
  input  logic               adj_min,
  input  logic               adj_hrs,
  output logic [SEC_U_W-1:0] sec_u,
  output logic [SEC_D_W-1:0] sec_d,
  output logic [MIN_U_W-1:0] min_u,
  output logic [MIN_D_W-1:0] min_d,
  output logic [HRS_U_W-1:0] hrs_u,
  output logic [HRS_D_W-1:0] hrs_d,
  output logic               sec_tick
`ifdef TIME_12H_EN
  ,
  output logic               pm
`endif
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]      prescaler;
  logic               any_adj, at_term, tick, tick_q;
  logic [SEC_U_W-1:0] s_u;
  logic [SEC_D_W-1:0] s_d;
  logic [MIN_U_W-1:0] m_u;
  logic [MIN_D_W-1:0] m_d;
  logic [HRS_U_W-1:0] h_u;
  logic [HRS_D_W-1:0] h_d;
  logic               su_c, sd_c, mu_c, md_c;
  logic               s_inc, m_inc, h_inc;

  assign any_adj = adj_sec | adj_min | adj_hrs;
  assign at_term = (prescaler == TERM);
  assign tick    = run && at_term && !any_adj;

  // Any adjust at terminal holds the prescaler so the tick lands a cycle later;
  // adj_sec instead restarts the second, dropping that tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prescaler <= '0;
    else if (adj_sec || tick)
      prescaler <= '0;
    else if (run && !at_term)
      prescaler <= prescaler + PW'(1);
  end

  // Adjust carries stay inside their own field; only tick carries propagate.
  assign s_inc = tick | adj_sec;
  assign m_inc = adj_min | (tick & sd_c);
  assign h_inc = adj_hrs | (tick & md_c);

  bcd_digit_counter #(.MOD(10), .W(SEC_U_W)) u_sec_u (
    .clk(clk), .reset(reset), .inc(s_inc), .clr(1'b0), .value(s_u), .carry_out(su_c)
  );
  bcd_digit_counter #(.MOD((SEC_MAX + 1) / 10), .W(SEC_D_W)) u_sec_d (
    .clk(clk), .reset(reset), .inc(su_c), .clr(1'b0), .value(s_d), .carry_out(sd_c)
  );
  bcd_digit_counter #(.MOD(10), .W(MIN_U_W)) u_min_u (
    .clk(clk), .reset(reset), .inc(m_inc), .clr(1'b0), .value(m_u), .carry_out(mu_c)
  );
  bcd_digit_counter #(.MOD((MIN_MAX + 1) / 10), .W(MIN_D_W)) u_min_d (
    .clk(clk), .reset(reset), .inc(mu_c), .clr(1'b0), .value(m_d), .carry_out(md_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_u <= '0;
      h_d <= '0;
    end else if (h_inc) begin
      if (h_d == HRS_D_W'(HRS_MAX / 10) && h_u == HRS_U_W'(HRS_MAX % 10)) begin
        h_u <= '0;
        h_d <= '0;
      end else if (h_u == HRS_U_W'(9)) begin
        h_u <= '0;
        h_d <= h_d + HRS_D_W'(1);
      end else begin
        h_u <= h_u + HRS_U_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tick_q <= 1'b0;
    else
      tick_q <= tick;
  end

`ifdef TIME_12H_EN
  logic [4:0] h24, h12;

  assign h24 = 5'(h_d) * 5'd10 + 5'(h_u);
  assign h12 = hrs_to_12h(h24);

  // Whole display is re-registered so every digit and the tick stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_u    <= '0;
      sec_d    <= '0;
      min_u    <= '0;
      min_d    <= '0;
      hrs_u    <= '0;
      hrs_d    <= '0;
      pm       <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      sec_u    <= s_u;
      sec_d    <= s_d;
      min_u    <= m_u;
      min_d    <= m_d;
      hrs_d    <= (h12 >= 5'd10) ? HRS_D_W'(1) : HRS_D_W'(0);
      hrs_u    <= (h12 >= 5'd10) ? HRS_U_W'(h12 - 5'd10) : HRS_U_W'(h12);
      pm       <= (h24 >= 5'd12);
      sec_tick <= tick_q;
    end
  end
`else
  assign sec_u    = s_u;
  assign sec_d    = s_d;
  assign min_u    = m_u;
  assign min_d    = m_d;
  assign hrs_u    = h_u;
  assign hrs_d    = h_d;
  assign sec_tick = tick_q;
`endif

endmodule

// File: tb/tb_time_counter_bcd.sv
// Self-checking bench for time_counter_bcd against a seconds-arithmetic reference model.
module tb_time_counter_bcd;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       adj_sec = 1'b0, adj_min = 1'b0, adj_hrs = 1'b0;
  logic [3:0] sec_u, min_u, hrs_u;
  logic [2:0] sec_d, min_d;
  logic [1:0] hrs_d;
  logic       sec_tick;
  logic       pm;

  int vecs = 0;
  int errs = 0;

`ifndef TIME_12H_EN
  assign pm = 1'b0;
`endif

  time_counter_bcd #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .run(run),
    .adj_sec(adj_sec), .adj_min(adj_min), .adj_hrs(adj_hrs),
    .sec_u(sec_u), .sec_d(sec_d), .min_u(min_u), .min_d(min_d),
    .hrs_u(hrs_u), .hrs_d(hrs_d), .sec_tick(sec_tick)
`ifdef TIME_12H_EN
    , .pm(pm)
`endif
  );

  always #5 clk = ~clk;

  wire [21:0] got = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, sec_tick, pm};

  typedef struct packed {
    int h; int m; int s; int p;
    bit tick; bit v;
  } mstate_t;

  mstate_t ms, ms_d;

  function automatic mstate_t zero_st(bit v);
    mstate_t z = '0;
    z.v = v;
    return z;
  endfunction

  function automatic mstate_t step(mstate_t c, bit r, bit as, bit am, bit ah);
    mstate_t n = c;
    bit term = r && (c.p == TPS - 1) && !(as || am || ah);
    int t;
    n.tick = term;
    if (term) begin
      t = (c.h * 3600 + c.m * 60 + c.s + 1) % 86400;
      n.h = t / 3600;
      n.m = (t / 60) % 60;
      n.s = t % 60;
      n.p = 0;
    end else begin
      if (as) begin
        n.s = (c.s + 1) % 60;
        n.p = 0;
      end else if (r && c.p != TPS - 1) begin
        n.p = c.p + 1;
      end
      if (am) n.m = (c.m + 1) % 60;
      if (ah) n.h = (c.h + 1) % 24;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms   <= zero_st(1'b1);
      ms_d <= zero_st(1'b0);
    end else begin
      ms   <= step(ms, run, adj_sec, adj_min, adj_hrs);
      ms_d <= ms;
    end
  end

  function automatic logic [21:0] expv();
    mstate_t e;
    int hh;
    bit pmv;
`ifdef TIME_12H_EN
    e = ms_d;
    if (!e.v) return '0;
    hh  = (e.h == 0) ? 12 : ((e.h > 12) ? e.h - 12 : e.h);
    pmv = (e.h >= 12);
`else
    e   = ms;
    hh  = e.h;
    pmv = 1'b0;
`endif
    return {2'(hh / 10), 4'(hh % 10), 3'(e.m / 10), 4'(e.m % 10),
            3'(e.s / 10), 4'(e.s % 10), e.tick, pmv};
  endfunction

  task automatic step_cyc(input bit as, input bit am, input bit ah);
    adj_sec = as;
    adj_min = am;
    adj_hrs = ah;
    @(posedge clk);
    @(negedge clk);
    adj_sec = 1'b0;
    adj_min = 1'b0;
    adj_hrs = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    run = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ms.h == h && ms.m == m && ms.s == s) break;
      step_cyc(ms.s != s, ms.m != m, ms.h != h);
    end
    step_cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (got !== 22'd0 || got !== expv()) begin
      $display("FAIL reset_state got=%h exp=%h", got, 22'd0);
      errs++;
    end
    reset = 1'b0;
  endtask

  task automatic test_tick();
    int n_ticks = 0;
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step_cyc(1'b0, 1'b0, 1'b0);
      if (sec_tick === 1'b1) n_ticks++;
      vecs++;
      if (got !== expv()) begin
        $display("FAIL tick_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
`ifndef TIME_12H_EN
      if (i == 4) begin
        vecs++;
        if (got !== {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd1, 1'b1, 1'b0}) begin
          $display("FAIL first_second got=%h exp=%h", got,
                   {2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd1, 1'b1, 1'b0});
          errs++;
        end
      end
`endif
    end
    vecs++;
`ifdef TIME_12H_EN
    if (n_ticks != 2) begin
      $display("FAIL tick_count got=%0d exp=%0d", n_ticks, 2);
`else
    if (n_ticks != 3) begin
      $display("FAIL tick_count got=%0d exp=%0d", n_ticks, 3);
`endif
      errs++;
    end
  endtask

  task automatic test_wrap();
    set_time(23, 59, 58);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step_cyc(1'b0, 1'b0, 1'b0);
      vecs++;
      if (got !== expv()) begin
        $display("FAIL wrap_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
      vecs++;
      if (sec_u > 9 || sec_d > 5 || min_u > 9 || min_d > 5 || hrs_u > 9 ||
          hrs_d > 2 || (hrs_d == 2 && hrs_u > 3)) begin
        $display("FAIL wrap_legal%0d got=%h exp=legal_bcd", i, got);
        errs++;
      end
    end
  endtask

  task automatic test_adjust();
    set_time(12, 59, 30);
    step_cyc(1'b0, 1'b1, 1'b0);
    vecs++;
    if (got !== expv()) begin
      $display("FAIL adj_min_wrap got=%h exp=%h", got, expv());
      errs++;
    end
`ifndef TIME_12H_EN
    vecs++;
    if (got !== {2'd1, 4'd2, 3'd0, 4'd0, 3'd3, 4'd0, 1'b0, 1'b0}) begin
      $display("FAIL adj_min_const got=%h exp=%h", got,
               {2'd1, 4'd2, 3'd0, 4'd0, 3'd3, 4'd0, 1'b0, 1'b0});
      errs++;
    end
`endif
    set_time(23, 17, 5);
    step_cyc(1'b0, 1'b0, 1'b1);
    step_cyc(1'b0, 1'b0, 1'b0);
    vecs++;
    if (got !== expv() || ms.h != 0 || ms.m != 17) begin
      $display("FAIL adj_hrs_wrap got=%h exp=%h", got, expv());
      errs++;
    end
  endtask

  task automatic wait_term(input string tag);
    int n = 0;
    run = 1'b1;
    while (ms.p != TPS - 1 && n < 10) begin
      step_cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    vecs++;
    if (ms.p != TPS - 1 || got !== expv()) begin
      $display("FAIL %s_reach_term got=%h exp=%h", tag, got, expv());
      errs++;
    end
  endtask

  task automatic test_collision();
    wait_term("col_min");
    step_cyc(1'b0, 1'b1, 1'b0);
    vecs++;
    if (got !== expv()) begin
      $display("FAIL col_min_defer got=%h exp=%h", got, expv());
      errs++;
    end
    step_cyc(1'b0, 1'b0, 1'b0);
    vecs++;
    if (got !== expv()) begin
      $display("FAIL col_min_tick got=%h exp=%h", got, expv());
      errs++;
    end
    wait_term("col_sec");
    for (int i = 0; i < TPS + 1; i++) begin
      step_cyc(i == 0, 1'b0, 1'b0);
      vecs++;
      if (got !== expv()) begin
        $display("FAIL col_sec_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
    end
  endtask

  task automatic test_run_off();
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_cyc(1'b0, 1'b0, 1'b0);
      vecs++;
      if (got !== expv() || (i > 1 && sec_tick !== 1'b0)) begin
        $display("FAIL run_off_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
    end
    step_cyc(1'b1, 1'b0, 1'b0);
    step_cyc(1'b0, 1'b0, 1'b0);
    vecs++;
    if (got !== expv()) begin
      $display("FAIL run_off_adj_sec got=%h exp=%h", got, expv());
      errs++;
    end
    run = 1'b1;
    for (int i = 0; i < 2 * TPS; i++) begin
      step_cyc(1'b0, 1'b0, 1'b0);
      vecs++;
      if (got !== expv()) begin
        $display("FAIL run_resume_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 7) != 0);
      step_cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0);
      vecs++;
      if (got !== expv()) begin
        $display("FAIL random_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
    end
  endtask

  task automatic test_async_reset();
    set_time(13, 42, 17);
    run = 1'b1;
    repeat (2) step_cyc(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (got !== 22'd0 || got !== expv()) begin
      $display("FAIL async_reset got=%h exp=%h", got, 22'd0);
      errs++;
    end
    adj_min = 1'b1;
    adj_sec = 1'b1;
    @(posedge clk);
    @(negedge clk);
    adj_min = 1'b0;
    adj_sec = 1'b0;
    vecs++;
    if (got !== 22'd0) begin
      $display("FAIL reset_adj_ignored got=%h exp=%h", got, 22'd0);
      errs++;
    end
    reset = 1'b0;
    for (int i = 0; i < TPS + 1; i++) begin
      step_cyc(1'b0, 1'b0, 1'b0);
      vecs++;
      if (got !== expv()) begin
        $display("FAIL post_reset_cycle%0d got=%h exp=%h", i, got, expv());
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_wrap();
    test_adjust();
    test_collision();
    test_run_off();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/time_counter_bcd.md
Name: time_counter_bcd

Overview:
Timekeeping stage feeding the clock display's digit/font path: owns the 1 s prescaler and the HH:MM:SS BCD registers. Replaces in-line multi-cycle digit carry logic.
- Digit outputs are always legal BCD.
- A full seconds-to-hours carry resolves in one cycle.
- Consumes the single-cycle adjust pulses from the button pulse generators and drives hrs/min/sec digits to the character mux.

Parameters:
TICKS_PER_SEC, 31500000, clk cycles per second; must be >= 2; prescaler width = $clog2(TICKS_PER_SEC).

Ports:
clk  in  1  pixel clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
run  in  1  1 = prescaler counts; 0 = prescaler frozen (adjustments still act)
adj_sec  in  1  single-cycle pulse: seconds +1
adj_min  in  1  single-cycle pulse: minutes +1
adj_hrs  in  1  single-cycle pulse: hours +1
sec_u  out  4  seconds units, 0..9
sec_d  out  3  seconds tens, 0..5
min_u  out  4  minutes units, 0..9
min_d  out  3  minutes tens, 0..5
hrs_u  out  4  hours units, 0..9
hrs_d  out  2  hours tens, 0..2
sec_tick  out  1  one-cycle pulse, high in the cycle the digits show a tick-driven advance

Behaviour:
- Reset (async assert, sync-safe deassert by system): prescaler = 0, all digits = 0 (00:00:00), sec_tick = 0.
- Prescaler counts 0..TICKS_PER_SEC-1 while run = 1.
- Terminal condition T is prescaler == TICKS_PER_SEC-1, run = 1 and no adj_* pulse this cycle. On the next edge:
  - prescaler -> 0
  - time advances by 1 s with full carry
  - sec_tick = 1 for exactly that cycle
- Latency from T to visible digits: 1 cycle. All outputs are registered; no combinational path from inputs to outputs.
- Carry chain, all in the same edge:
  - sec_u 9->0 carries into sec_d; sec_d 5->0 carries into min_u; min_u 9->0 carries into min_d; min_d 5->0 carries into hours.
  - Hours 23:59:59 -> 00:00:00.
  - hrs_u wraps 9->0 with hrs_d+1 only when hrs_d < 2.
- Adjust pulses:
  - Each pulse increments only its own field modulo its range (sec 0..59, min 0..59, hrs 0..23), with no carry into the next field. Example: 12:59:xx + adj_min -> 12:00:xx.
  - adj_sec additionally clears the prescaler to 0, so the next tick is a full second later.
  - Simultaneous adj pulses on different fields all apply in the same cycle.
- Tick vs adjust collision: if any adj_* is high while the prescaler is at terminal with run = 1, the tick is deferred. The prescaler holds at TICKS_PER_SEC-1 and the tick fires the following cycle, unless adj_sec is present, in which case the prescaler clears and the tick is dropped.
- run = 0: prescaler holds its value and sec_tick stays 0; adjustments behave normally.
- Reset mid-count or mid-adjust returns immediately to 00:00:00 and prescaler 0; a pulse coincident with reset is ignored.
- Digit registers never hold out-of-range values (no transient 10 or 6 states).

Optional Feature:
Macro TIME_12H_EN.
- Defined:
  - Adds output port pm (1 bit).
  - Hours are still kept internally as 0..23.
  - Output hour digits are registered 12-hour mapping: 0 -> 12 (pm=0), 1..11 -> 1..11 (pm=0), 12 -> 12 (pm=1), 13..23 -> 1..11 (pm=1).
  - Output digit latency rises to 2 cycles from T.
  - sec_tick is aligned with the displayed update.
- Undefined: 24-hour outputs as above, no pm port, 1-cycle latency.

Decomposition:
- Shared package vga_clock_pkg holds:
  - digit widths: SEC_U_W = 4, SEC_D_W = 3, HRS_D_W = 2, etc.
  - field limits: SEC_MAX = 59, MIN_MAX = 59, HRS_MAX = 23
  - default TICKS_PER_SEC
- One sub-module, bcd_digit_counter (parameters MOD and W), provides:
  - inputs inc and clr
  - outputs value and carry_out (combinational, = inc && value == MOD-1)
- Seconds and minutes each use two bcd_digit_counter instances. Hours use dedicated logic for the 23 -> 0 wrap.

Test Plan:
- Reset with TICKS_PER_SEC = 4, run = 1: digits 00:00:00. After 4 clocks the digits read 00:00:01 and sec_tick is high for one cycle; sec_tick pulses every 4 cycles thereafter.
- Preload 23:59:58 via adj pulses, then run 8 cycles: 23:59:59, then 00:00:00 with every digit changing on the same edge, and no intermediate illegal value seen on any cycle.
- At 12:59:30, pulse adj_min: result is 12:00:30. At 23:xx, pulse adj_hrs: hours wrap to 00 and minutes are unchanged.
- Prescaler at 3 (terminal) with adj_min pulsed: tick deferred 1 cycle and seconds advance the following cycle. Repeat with adj_sec: seconds +1 exactly once, prescaler = 0.
- run = 0 for 20 cycles: digits constant and sec_tick never asserted. Pulse adj_sec: seconds +1. Set run = 1: ticks resume counting from prescaler 0.
- TIME_12H_EN defined, internal 00 and 13: outputs 12 with pm = 0, and 01 with pm = 1. Assert reset asynchronously mid-count: all outputs clear before the next clock edge.
